// File: rtl/stop_result_writer_if.sv
// Result-stream and BRAM write-port bundle for stop_result_writer.
interface stop_result_writer_if #(
  parameter int IN_DATA_WITDH = 8,
  parameter int ADDR_WIDTH    = 32
);
  logic                       i_start;
  logic [ADDR_WIDTH-1:0]      i_base_addr;
  logic                       i_valid;
  logic [2*IN_DATA_WITDH-1:0] i_result0;
  logic [2*IN_DATA_WITDH-1:0] i_result1;
  logic                       o_bram_en;
  logic [3:0]                 o_bram_we;
  logic [ADDR_WIDTH-1:0]      o_bram_addr;
  logic [31:0]                o_bram_wdata;
  logic                       o_busy;
  logic                       o_done;
  logic                       o_err;

  modport master (
    output i_start, i_base_addr, i_valid,
    output i_result0, i_result1,
    input  o_bram_en, o_bram_we, o_bram_addr,
    input  o_bram_wdata, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_base_addr, i_valid,
    input  i_result0, i_result1,
    output o_bram_en, o_bram_we, o_bram_addr,
    output o_bram_wdata, o_busy, o_done, o_err
  );
endinterface

// File: rtl/stop_result_writer.sv
// Packs block-multiply result beats into 32-bit words and
// streams them to a BRAM port at consecutive byte addresses.
module stop_result_writer #(
  parameter int IN_DATA_WITDH = 8,
  parameter int BLOCK_SIZE    = 16,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  stop_result_writer_if.slave   bus
);
  localparam int BEATS = BLOCK_SIZE * BLOCK_SIZE / 2;
  localparam int CW    = $clog2(BEATS) + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_en;
  logic [3:0]            r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  w_last;

  assign w_last = (r_cnt == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_en    <= 1'b0;
      r_we    <= 4'h0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_en   <= 1'b0;
      r_we   <= 4'h0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_ptr   <= bus.i_base_addr;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else if (bus.i_valid) begin
            r_err <= 1'b1;
          end
        end
        RUN: begin
          if (bus.i_valid) begin
            r_en    <= 1'b1;
            r_we    <= 4'hF;
            r_addr  <= r_ptr;
            r_wdata <= {bus.i_result1, bus.i_result0};
            r_ptr   <= r_ptr + ADDR_WIDTH'(4);
            r_cnt   <= r_cnt + 1'b1;
            // final beat: done rides with its write
            if (w_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_bram_en    = r_en;
  assign bus.o_bram_we    = r_we;
  assign bus.o_bram_addr  = r_addr;
  assign bus.o_bram_wdata = r_wdata;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_err        = r_err;
endmodule

// File: doc/stop_result_writer.md
Name: stop_result_writer

Overview:
- Downstream stage of the 16x16 block-multiply core. Consumes its result stream: two 2*IN_DATA_WITDH-bit results per valid beat, row-major.
- Packs each beat into one 32-bit word and writes it to a BRAM port at consecutive byte addresses from a base address latched at start.
- Counts beats against BLOCK_SIZE*BLOCK_SIZE/2, pulses done after the final write, and flags stray beats.

Parameters:
- IN_DATA_WITDH, 8: operand width; each result is 2*IN_DATA_WITDH bits (16).
- BLOCK_SIZE, 16: block is BLOCK_SIZE x BLOCK_SIZE; beats per block = BLOCK_SIZE*BLOCK_SIZE/2 = 128.
- ADDR_WIDTH, 32: BRAM byte-address width.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that arms the writer for one block.
- i_base_addr  in  ADDR_WIDTH  byte base address; sampled only when i_start is accepted.
- i_valid  in  1  result beat valid.
- i_result0  in  2*IN_DATA_WITDH  even-column result, C[i][j].
- i_result1  in  2*IN_DATA_WITDH  odd-column result, C[i][j+1].
- o_bram_en  out  1  BRAM enable.
- o_bram_we  out  4  byte write enables; 4'hF on a write, else 0.
- o_bram_addr  out  ADDR_WIDTH  BRAM byte address.
- o_bram_wdata  out  32  packed word {i_result1, i_result0}.
- o_busy  out  1  high while armed (RUN).
- o_done  out  1  one-cycle pulse with the final write.
- o_err  out  1  sticky stray-beat flag.

Behaviour:
- Reset (synchronous, active-high) drives every output to 0: en, we, addr, wdata, busy, done, err. State goes to IDLE, beat counter and address pointer to 0.
- Reset asserted mid-block aborts the block. No further writes, no done.
- States: IDLE, RUN.
- IDLE:
  - i_start=1: latch i_base_addr into the pointer, clear counter and o_err, go to RUN. o_busy is 1 from the next cycle.
  - i_valid in the same cycle as i_start is ignored and does not set o_err.
  - i_valid=1 without i_start: beat dropped, o_err set to 1. o_err holds until the next accepted i_start or reset.
- RUN, each cycle with i_valid=1:
  - Next cycle: o_bram_en=1, o_bram_we=4'hF, o_bram_addr=pointer, o_bram_wdata={i_result1,i_result0}.
  - Pointer increments by 4 and counter by 1.
  - Latency is exactly 1 cycle; back-to-back beats give back-to-back writes.
  - The writer has no backpressure; every beat in RUN is written.
- RUN, cycle with i_valid=0: next cycle en=0, we=0. addr and wdata hold their last values.
- RUN, i_start ignored (no re-latch, no error).
- Last beat (counter = BLOCK_SIZE*BLOCK_SIZE/2 - 1) accepted at cycle N:
  - Cycle N+1 carries the final write plus o_done=1 and o_busy=0; state returns to IDLE.
  - A beat at N+1 counts as stray and sets o_err.
- Width rules:
  - Results are packed unmodified, result0 in bits [15:0] and result1 in [31:16].
  - Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently.
  - The beat counter is clog2(BLOCK_SIZE*BLOCK_SIZE/2)+1 bits wide.

Test Plan:
- Reset then idle: hold reset 3 cycles, release -> all outputs 0, o_busy=0, no writes for 20 cycles.
- Full block, base 0x1000: i_start, then 128 consecutive beats with result0=2k, result1=2k+1 (k=0..127) -> 128 writes at 0x1000..0x11FC step 4. Write k has wdata={16'(2k+1),16'(2k)}. o_done is a single pulse with the write to 0x11FC; o_busy low afterwards.
- Gapped stream: 128 beats with i_valid toggling 1,0,1,0 -> writes only in the cycles after valid beats, addresses contiguous, exactly one o_done after the 128th write.
- Stray beat: i_valid with result0=0xAAAA while IDLE -> no write, o_err=1. o_err stays 1 until the next i_start, which clears it.
- Start+valid collision and restart: i_start and i_valid in the same IDLE cycle -> beat ignored, o_err=0. A second i_start at beat 50 is ignored and the block completes at base+0x1FC.
- Mid-block reset: reset after beat 60 -> outputs 0 the next cycle, no o_done. A new i_start with base 0x2000 runs a clean 128-beat block from 0x2000.
